// File: rtl/snoop_fifo_pkg.sv
// Shared defaults and helpers for the snoopable request FIFO.
// Optional build macro used by the top: SNOOP_FIFO_WR_BYPASS_EN.
package snoop_fifo_pkg;

  localparam int SF_DATA_W  = 132;
  localparam int SF_DEPTH   = 20;
  localparam int SF_KEY_W   = 16;
  localparam int SF_KEY_LSB = 0;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int sf_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer advance with explicit wrap, so non-power-of-two depths work.
  function automatic int unsigned sf_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/snoop_fifo_cmp.sv
// Occupancy-masked key comparator bank: one equality check per entry, OR-reduced to a hit.
module snoop_fifo_cmp
  import snoop_fifo_pkg::*;
#(
  parameter int DEPTH = SF_DEPTH,
  parameter int KEY_W = SF_KEY_W
) (
  input  logic [DEPTH-1:0][KEY_W-1:0] i_keys,
  input  logic [DEPTH-1:0]            i_occ,
  input  logic [KEY_W-1:0]            i_key,
  output logic                        o_hit
);

  logic [DEPTH-1:0] w_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_match[gi] = i_occ[gi] && (i_keys[gi] == i_key);
  end

  assign o_hit = |w_match;

endmodule

// File: rtl/snoop_fifo_param.sv
// Parametrised first-word-fall-through FIFO with a registered key snoop over occupied entries.
// Build option: define SNOOP_FIFO_WR_BYPASS_EN to let a same-cycle write hit the snoop.
module snoop_fifo_param
  import snoop_fifo_pkg::*;
#(
  parameter int DATA_W  = SF_DATA_W,
  parameter int DEPTH   = SF_DEPTH,
  parameter int KEY_W   = SF_KEY_W,
  parameter int KEY_LSB = SF_KEY_LSB
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [DATA_W-1:0]                wdata,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rvalid,
  input  logic                             rready,
  input  logic [KEY_W-1:0]                 sdata,
  input  logic                             svalid,
  output logic                             smatch,
  output logic                             smatch_vld,
  output logic [sf_cnt_w(DEPTH)-1:0]       count
);

  localparam int CNT_W = sf_cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_occ;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_smatch;
  logic              r_smatch_vld;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_hit_mem;
  logic                        w_hit;
  logic [DEPTH-1:0][KEY_W-1:0] w_keys;

  // Full is judged on count alone; a pop in the same cycle does not free a slot early.
  assign wready = (r_count != CNT_W'(DEPTH));
  assign rvalid = (r_count != '0);
  assign rdata  = r_mem[r_rd_ptr];
  assign count  = r_count;

  assign w_push = wvalid && wready;
  assign w_pop  = rvalid && rready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(sf_wrap_inc(32'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= PTR_W'(sf_wrap_inc(32'(r_rd_ptr), DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Push and pop never target the same slot: that would need the FIFO to be both empty and full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_occ[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) r_occ[r_rd_ptr] <= 1'b0;
    end
  end

  always_comb begin
    w_keys = '0;
    for (int i = 0; i < DEPTH; i++) w_keys[i] = r_mem[i][KEY_LSB +: KEY_W];
  end

  snoop_fifo_cmp #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_cmp (
    .i_keys (w_keys),
    .i_occ  (r_occ),
    .i_key  (sdata),
    .o_hit  (w_hit_mem)
  );

`ifdef SNOOP_FIFO_WR_BYPASS_EN
  assign w_hit = w_hit_mem || (w_push && (wdata[KEY_LSB +: KEY_W] == sdata));
`else
  assign w_hit = w_hit_mem;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_smatch     <= 1'b0;
      r_smatch_vld <= 1'b0;
    end else begin
      r_smatch     <= svalid && w_hit;
      r_smatch_vld <= svalid;
    end
  end

  assign smatch     = r_smatch;
  assign smatch_vld = r_smatch_vld;

endmodule

// File: tb/tb_snoop_fifo_param.sv
// Scoreboard bench for snoop_fifo_param: queue-based reference model, directed cases then random traffic.
module tb_snoop_fifo_param;
  import snoop_fifo_pkg::*;

  localparam int DW    = SF_DATA_W;
  localparam int DEPTH = SF_DEPTH;
  localparam int KW    = SF_KEY_W;
  localparam int KL    = SF_KEY_LSB;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic [KW-1:0] sdata;
  logic          svalid;
  logic          smatch;
  logic          smatch_vld;
  logic [CW-1:0] count;

  snoop_fifo_param dut (
    .clk        (clk),
    .rstn       (rstn),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .sdata      (sdata),
    .svalid     (svalid),
    .smatch     (smatch),
    .smatch_vld (smatch_vld),
    .count      (count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model  [$];
  logic [DW-1:0] exp_rd [$];
  bit            exp_snp[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [KW-1:0] k);
    logic [159:0] t;
    logic [DW-1:0] d;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d = t[DW-1:0];
    d[KL +: KW] = k;
    return d;
  endfunction

  // One clock: drive inputs, predict from the model's pre-edge contents, then advance.
  task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr,
                       input bit sv, input logic [KW-1:0] sd);
    bit push, pop, hit;
    wvalid = wv; wdata = wd; rready = rr; svalid = sv; sdata = sd;
    push = wv && (model.size() < DEPTH);
    pop  = rr && (model.size() > 0);
    if (sv) begin
      hit = 1'b0;
      foreach (model[i]) if (model[i][KL +: KW] == sd) hit = 1'b1;
`ifdef SNOOP_FIFO_WR_BYPASS_EN
      if (push && wd[KL +: KW] == sd) hit = 1'b1;
`endif
      exp_snp.push_back(hit);
    end
    if (pop) begin
      exp_rd.push_back(model[0]);
      void'(model.pop_front());
    end
    if (push) model.push_back(wd);
    @(posedge clk); #1;
    chk("count",  DW'(count),  DW'(model.size()));
    chk("wready", DW'(wready), DW'(model.size() != DEPTH));
    chk("rvalid", DW'(rvalid), DW'(model.size() != 0));
    $display("[TB] t=%0t wv=%0b rr=%0b sv=%0b sd=%0h push=%0b pop=%0b count=%0d",
             $time, wv, rr, sv, sd, push, pop, count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    wvalid = 1'b0; rready = 1'b0; svalid = 1'b0; wdata = '0; sdata = '0;
    rstn = 1'b0;
    #2;
    model.delete(); exp_rd.delete(); exp_snp.delete();
    chk("rst_count",  DW'(count),      '0);
    chk("rst_rvalid", DW'(rvalid),     '0);
    chk("rst_wready", DW'(wready),     DW'(1));
    chk("rst_smvld",  DW'(smatch_vld), '0);
    chk("rst_rdata",  rdata,           '0);
    #4 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: compares pops and snoop results against the expectation queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid && rready) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no pop", rdata);
        end else begin
          chk("rdata", rdata, exp_rd.pop_front());
        end
      end
      if (smatch_vld) begin
        if (exp_snp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL smatch_vld_unexpected: got 1 expected 0");
        end else begin
          chk("smatch", DW'(smatch), DW'(exp_snp.pop_front()));
        end
      end else begin
        chk("smatch_idle", DW'(smatch), '0);
      end
    end
  end

  initial begin
    logic [KW-1:0] k;
    rstn = 1'b0; wvalid = 1'b0; rready = 1'b0; svalid = 1'b0; wdata = '0; sdata = '0;
    @(posedge clk); #1;
    chk("init_count",  DW'(count),  '0);
    chk("init_wready", DW'(wready), DW'(1));
    chk("init_rvalid", DW'(rvalid), '0);
    chk("init_smatch", DW'(smatch), '0);
    chk("init_rdata",  rdata,       '0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    cycle(1'b0, '0, 1'b0, 1'b1, KW'(16'h1234));

    // Fill to full, try one more, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(KW'(i)), 1'b0, 1'b0, '0);
    cycle(1'b1, mk(KW'(16'h0bad)), 1'b0, 1'b1, KW'(16'h0bad));
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Wrap across the last index, then snoop live and stale keys.
    for (int i = 0; i < 15; i++) cycle(1'b1, mk(KW'(i)), 1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(KW'(16'h100 + i)), 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, KW'(16'h109));
    cycle(1'b0, '0, 1'b0, 1'b1, KW'(16'h005));
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Full with simultaneous write and pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(KW'(16'h200 + i)), 1'b0, 1'b0, '0);
    cycle(1'b1, mk(KW'(16'h300)), 1'b1, 1'b0, '0);
    cycle(1'b1, mk(KW'(16'h301)), 1'b1, 1'b0, '0);

    // Snoop the head while it pops, then again after it is gone.
    k = model[0][KL +: KW];
    cycle(1'b0, '0, 1'b1, 1'b1, k);
    cycle(1'b0, '0, 1'b0, 1'b1, k);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);

    // Snoop a key in the same cycle it is written, then the cycle after.
    cycle(1'b1, mk(KW'(16'h777)), 1'b0, 1'b1, KW'(16'h777));
    cycle(1'b0, '0, 1'b0, 1'b1, KW'(16'h777));
    idle(2);

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      bit wv, rr, sv;
      if (n == 1500) do_reset();
      wv = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rr = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      sv = $urandom_range(0, 1) == 1;
      cycle(wv, mk(KW'($urandom_range(0, 31))), rr, sv, KW'($urandom_range(0, 31)));
    end
    idle(3);

    chk("exp_rd_drained",  DW'(exp_rd.size()),  '0);
    chk("exp_snp_drained", DW'(exp_snp.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
